// File: rtl/vga_scan_driver.sv
// VGA scan driver: raster counters, sync/blank decode and an 8-entry palette.
// Sync and blank are delayed so they line up with the renderer's colour data.
module vga_scan_driver #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RENDER_LAT = 0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  output logic [9:0] o_n_PixelPos_X,
  output logic [9:0] o_n_PixelPos_Y,
  input  logic [2:0] i_pixelState,
  output logic [7:0] o_Red,
  output logic [7:0] o_Green,
  output logic [7:0] o_Blue,
  output logic       o_hSync,
  output logic       o_vSync,
  output logic       o_Blank,
  output logic       o_FrameStart
);

  localparam logic [9:0] HLast      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VLast      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HActive    = 10'(H_ACTIVE);
  localparam logic [9:0] VActive    = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] xCount_q, xCount_d;
  logic [9:0] yCount_q, yCount_d;

  always_comb begin
    xCount_d = xCount_q + 10'd1;
    yCount_d = yCount_q;
    if (xCount_q == HLast) begin
      xCount_d = '0;
      yCount_d = (yCount_q == VLast) ? '0 : yCount_q + 10'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      xCount_q <= '0;
      yCount_q <= '0;
    end else begin
      xCount_q <= xCount_d;
      yCount_q <= yCount_d;
    end
  end

  // Timing bundle {blank, hSync, vSync}; the all-ones value is the idle state.
  logic [2:0] timing_c;
  logic [2:0] timingTap;

  assign timing_c = {
    (xCount_q >= HActive) || (yCount_q >= VActive),
    !((xCount_q >= HSyncStart) && (xCount_q < HSyncEnd)),
    !((yCount_q >= VSyncStart) && (yCount_q < VSyncEnd))
  };

  generate
    if (RENDER_LAT == 0) begin : gNoDelay
      assign timingTap = timing_c;
    end else begin : gDelay
      logic [2:0] stage_q [RENDER_LAT];
      always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
          for (int i = 0; i < RENDER_LAT; i++) stage_q[i] <= 3'b111;
        end else begin
          stage_q[0] <= timing_c;
          for (int i = 1; i < RENDER_LAT; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign timingTap = stage_q[RENDER_LAT-1];
    end
  endgenerate

  logic [23:0] rgb_d, rgb_q;
  logic        blank_q, hSync_q, vSync_q;

  always_comb begin
    rgb_d = 24'h000000;
    if (!timingTap[2]) begin
      case (i_pixelState)
        3'd0: rgb_d = 24'h000000;
        3'd1: rgb_d = 24'hFFFFFF;
        3'd2: rgb_d = 24'hFF0000;
        3'd3: rgb_d = 24'hFFFF00;
        3'd4: rgb_d = 24'h00FFFF;
        3'd5: rgb_d = 24'h00FF00;
        3'd6: rgb_d = 24'h0000FF;
        default: rgb_d = 24'hFF00FF;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      rgb_q   <= '0;
      blank_q <= 1'b1;
      hSync_q <= 1'b1;
      vSync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      blank_q <= timingTap[2];
      hSync_q <= timingTap[1];
      vSync_q <= timingTap[0];
    end
  end

  assign o_n_PixelPos_X = xCount_q;
  assign o_n_PixelPos_Y = yCount_q;
  assign o_FrameStart   = (xCount_q == 10'd0) && (yCount_q == 10'd0);
  assign o_Red          = rgb_q[23:16];
  assign o_Green        = rgb_q[15:8];
  assign o_Blue         = rgb_q[7:0];
  assign o_Blank        = blank_q;
  assign o_hSync        = hSync_q;
  assign o_vSync        = vSync_q;

endmodule
